// File: rtl/signed_iter_pkg.sv
// signed_iter_pkg
//   Shared definitions for the signed range iterator: the FSM state encoding
//   (also usable by benches to decode state) and a small helper used to
//   decide whether a step is headed downwards.
package signed_iter_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;  // waiting for start
  localparam state_t ST_CHECK = 2'd1;  // evaluating cond(start_val)
  localparam state_t ST_RUN   = 2'd2;  // presenting index beats
  localparam state_t ST_FIN   = 2'd3;  // one-cycle done pulse

  // The sign bit of the step selects the comparison direction:
  // 0 = counting up (idx vs limit with < / <=), 1 = counting down (> / >=).
  function automatic logic step_is_down(input logic sign_bit);
    return sign_bit;
  endfunction

endpackage

// File: rtl/signed_bound_cmp.sv
// signed_bound_cmp
//   Purely combinational loop-bound test on signed two's complement values.
//   Ports:
//     a     in  WIDTH  candidate index
//     b     in  WIDTH  loop limit
//     dir   in  1      0 = ascending (a < b / a <= b), 1 = descending (a > b / a >= b)
//     incl  in  1      1 = bound itself is part of the range
//     pass  out 1      a is inside the range
module signed_bound_cmp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             dir,
  input  logic             incl,
  output logic             pass
);

  logic lt;
  logic eq;

  always_comb begin
    lt = $signed(a) < $signed(b);
    eq = (a == b);
    if (!dir) begin
      pass = lt | (incl & eq);
    end else begin
      // a > b is "not less and not equal"; a >= b is simply "not less".
      pass = ~lt & (incl | ~eq);
    end
  end

endmodule

// File: rtl/signed_range_iter.sv
// signed_range_iter
//   Emits the index sequence of a signed for-loop
//     for (idx = start_val; cond(idx); idx += step)
//   one beat at a time on a valid/ready stream. Overflow of idx+step or a
//   zero step terminates the run (that beat is flagged last) and sets err.
//   Ports:
//     clk        in   1          clock, all state on rising edge
//     reset      in   1          synchronous active-high reset
//     start      in   1          begin a run (accepted only when idle)
//     start_val  in   WIDTH      signed initial index
//     limit      in   WIDTH      signed loop bound
//     step       in   WIDTH      signed increment
//     incl       in   1          1 = inclusive bound
//     out_valid  out  1          index beat available
//     out_ready  in   1          consumer accepts the beat
//     index      out  WIDTH      current index
//     last       out  1          current beat ends the run
//     busy       out  1          not idle
//     done       out  1          one-cycle completion pulse
//     count      out  CNT_WIDTH  beats accepted this run (saturating)
//     err        out  1          run ended by overflow or zero step
module signed_range_iter
  import signed_iter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     start_val,
  input  logic [WIDTH-1:0]     limit,
  input  logic [WIDTH-1:0]     step,
  input  logic                 incl,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     index,
  output logic                 last,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 err
);

  // --------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------
  state_t               state_reg;
  state_t               state_next;
  logic [WIDTH-1:0]     start_reg;
  logic [WIDTH-1:0]     limit_reg;
  logic [WIDTH-1:0]     step_reg;
  logic                 incl_reg;
  logic [WIDTH-1:0]     index_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic                 err_reg;

  // --------------------------------------------------------------------
  // Next-index arithmetic. Both operands are sign-extended by one bit so
  // the sum is exact; overflow shows up as the top two bits disagreeing.
  // --------------------------------------------------------------------
  logic             dir;
  logic [WIDTH:0]   nxt_wide;
  logic [WIDTH-1:0] nxt;
  logic             ovf;
  logic             step_zero;
  logic             cond_start;
  logic             cond_nxt;
  logic             end_of_run;
  logic             xfer;

  assign dir       = step_is_down(step_reg[WIDTH-1]);
  assign nxt_wide  = {index_reg[WIDTH-1], index_reg} + {step_reg[WIDTH-1], step_reg};
  assign nxt       = nxt_wide[WIDTH-1:0];
  assign ovf       = nxt_wide[WIDTH] ^ nxt_wide[WIDTH-1];
  assign step_zero = (step_reg == '0);

  signed_bound_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp_start (
    .a    (start_reg),
    .b    (limit_reg),
    .dir  (dir),
    .incl (incl_reg),
    .pass (cond_start)
  );

  // When ovf is set the truncated nxt is meaningless, but ovf alone already
  // forces end_of_run so the comparator result is don't-care in that case.
  signed_bound_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp_nxt (
    .a    (nxt),
    .b    (limit_reg),
    .dir  (dir),
    .incl (incl_reg),
    .pass (cond_nxt)
  );

  assign end_of_run = ovf | step_zero | ~cond_nxt;
  assign xfer       = (state_reg == ST_RUN) & out_ready;

  // --------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // --------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_CHECK;
      ST_CHECK: state_next = cond_start ? ST_RUN : ST_FIN;
      ST_RUN:   if (xfer && end_of_run) state_next = ST_FIN;
      ST_FIN:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------
  // FSM: outputs (Moore-style, decoded from the registered state)
  // --------------------------------------------------------------------
  always_comb begin
    out_valid = (state_reg == ST_RUN);
    busy      = (state_reg != ST_IDLE);
    done      = (state_reg == ST_FIN);
    last      = (state_reg == ST_RUN) & end_of_run;
  end

  assign index = index_reg;
  assign count = count_reg;
  assign err   = err_reg;

  // --------------------------------------------------------------------
  // Datapath registers. Operands are latched once per run so that later
  // changes on the input pins (including an ignored start) cannot disturb
  // the run in progress.
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      start_reg <= '0;
      limit_reg <= '0;
      step_reg  <= '0;
      incl_reg  <= 1'b0;
      index_reg <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && start) begin
        start_reg <= start_val;
        limit_reg <= limit;
        step_reg  <= step;
        incl_reg  <= incl;
        count_reg <= '0;
        err_reg   <= 1'b0;
      end

      if (state_reg == ST_CHECK && cond_start) begin
        index_reg <= start_reg;
      end

      if (xfer) begin
        if (count_reg != '1) begin
          count_reg <= count_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        if (end_of_run) begin
          err_reg <= ovf | step_zero;
        end else begin
          index_reg <= nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_signed_range_iter.sv
// Scoreboard bench for signed_range_iter (WIDTH=8, CNT_WIDTH=4 so that both
// overflow and count saturation are reachable in short runs).
module tb_signed_range_iter;

  localparam int W      = 8;
  localparam int CW     = 4;
  localparam int IMAX   = 127;
  localparam int IMIN   = -128;
  localparam int CNTMAX = 15;

  typedef struct {
    int idx;
    bit last;
  } beat_t;

  typedef struct {
    int cnt;
    bit err;
  } end_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  start_val;
  logic [W-1:0]  limit;
  logic [W-1:0]  step;
  logic          incl;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  index;
  logic          last;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
  logic          err;

  int checks = 0;
  int errors = 0;
  int beats_seen = 0;
  int ready_mode = 0;

  beat_t beat_q[$];
  end_t  end_q[$];

  signed_range_iter #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_val (start_val),
    .limit     (limit),
    .step      (step),
    .incl      (incl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .index     (index),
    .last      (last),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer loop following the iteration rules.
  function automatic bit cond_f(input int i, input int lim, input int st, input bit inc);
    if (st >= 0) return inc ? (i <= lim) : (i < lim);
    else         return inc ? (i >= lim) : (i > lim);
  endfunction

  task automatic model(input int sv, input int lim, input int st, input bit inc, output bit empty);
    int    idx;
    int    nx;
    int    n;
    bit    fin;
    bit    l;
    bit    er;
    beat_t b;
    end_t  e;
    idx = sv; n = 0; fin = 0; er = 0;
    empty = !cond_f(sv, lim, st, inc);
    while (!empty && !fin) begin
      nx = idx + st;
      er = (st == 0) || (nx > IMAX) || (nx < IMIN);
      l  = er || !cond_f(nx, lim, st, inc);
      b.idx = idx; b.last = l;
      beat_q.push_back(b);
      n++;
      if (l) fin = 1;
      else   idx = nx;
    end
    e.cnt = (n > CNTMAX) ? CNTMAX : n;
    e.err = empty ? 1'b0 : er;
    end_q.push_back(e);
  endtask

  // Consumer: ready pattern selected per test (always / toggle / random).
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares every accepted beat and every completion against the
  // scoreboard queues, and checks that a stalled beat is held.
  bit           prev_stall = 0;
  logic [W-1:0] prev_idx   = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_index", int'($signed(index)), int'($signed(prev_idx)));
      end
      if (out_valid && out_ready) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", int'($signed(index)), 9999);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_index", int'($signed(index)), b.idx);
          chk("beat_last", int'(last), int'(b.last));
        end
        beats_seen++;
      end
      prev_stall = out_valid && !out_ready;
      prev_idx   = index;
      if (done) begin
        chk("beats_left_at_done", beat_q.size(), 0);
        if (end_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          end_t e;
          e = end_q.pop_front();
          chk("final_count", int'(count), e.cnt);
          chk("final_err", int'(err), int'(e.err));
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_index"}, int'(index), 0);
    chk({tag, "_last"}, int'(last), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  task automatic issue_start(input int sv, input int lim, input int st, input bit inc);
    @(posedge clk);
    #1;
    start_val = W'(sv);
    limit     = W'(lim);
    step      = W'(st);
    incl      = inc;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("check_state_busy", int'(busy), 1);
    chk("check_state_no_valid", int'(out_valid), 0);
  endtask

  task automatic run(input int sv, input int lim, input int st, input bit inc, input bit repulse);
    bit empty;
    bit seen;
    model(sv, lim, st, inc, empty);
    issue_start(sv, lim, st, inc);
    @(posedge clk);
    #1;
    // Two cycles after start: either the first beat or the done pulse.
    if (empty) chk("empty_done_latency", int'(done), 1);
    else       chk("first_valid_latency", int'(out_valid), 1);
    seen = 0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (repulse && c == 3 && busy) begin
        start     = 1'b1;
        start_val = W'($urandom);
        limit     = W'($urandom);
        step      = W'($urandom);
        incl      = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge clk);
    #1;
    chk("idle_after_done", int'(busy), 0);
  endtask

  task automatic run_with_reset;
    bit empty;
    int seen2;
    ready_mode = 1;
    model(-3, 2, 2, 1'b1, empty);
    beats_seen = 0;
    issue_start(-3, 2, 2, 1'b1);
    seen2 = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (beats_seen >= 2) begin
        seen2 = 1;
        break;
      end
    end
    if (seen2 == 0) chk("second_beat_timeout", 0, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("midrun_reset");
    reset = 1'b0;
    beat_q.delete();
    end_q.delete();
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    start_val = '0;
    limit     = '0;
    step      = '0;
    incl      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");

    // Reset wins over a simultaneous start.
    start_val = 8'd1; limit = 8'd5; step = 8'd1; incl = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_over_start_busy", int'(busy), 0);
    start = 1'b0;
    reset = 1'b0;

    ready_mode = 0;
    run(2, -1, 1, 1'b1, 1'b0);       // empty range, signed compare
    run(-3, 2, 2, 1'b1, 1'b0);       // -3,-1,1
    run(5, 0, -1, 1'b0, 1'b0);       // 5..1 descending exclusive
    run(120, 127, 5, 1'b1, 1'b0);    // ends on overflow
    ready_mode = 1;
    run(-3, 2, 2, 1'b1, 1'b0);       // same beats under back-pressure
    ready_mode = 0;
    run(7, 7, 0, 1'b1, 1'b0);        // zero step: one beat then err
    ready_mode = 2;
    run(-10, 20, 1, 1'b0, 1'b1);     // start re-pulsed mid-run
    run(0, 20, 1, 1'b0, 1'b0);       // 20 beats, count saturates
    run(-120, -128, -3, 1'b1, 1'b0); // negative overflow

    run_with_reset();

    for (int r = 0; r < 25; r++) begin
      int sv;
      int lim;
      int st;
      ready_mode = int'($urandom_range(0, 2));
      sv  = int'($urandom_range(0, 255)) - 128;
      lim = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 3) == 0) st = int'($urandom_range(0, 255)) - 128;
      else                           st = int'($urandom_range(0, 14)) - 7;
      run(sv, lim, st, 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
